pc_counter163: RTL and testbench
================================

Name: pc_counter163

Overview:
- Synchronous binary up-counter used as the tinycpu program counter. Behaviour matches one or more cascaded 74163 slices.
- Sits directly downstream of the quad-NAND decode logic. A NAND output drives load_n, an active-low parallel-load strobe used for jumps and branches.
- Each 4-bit slice is modelled as a 74163 nibble with an internal ripple-carry chain, so the counter reproduces board-level timing and carry behaviour.

Parameters:
- WIDTH, 8: counter width in bits. Must be a multiple of 4; each group of 4 bits is one 74163 slice.
- NSLICE, WIDTH/4: number of cascaded slices. Derived, not overridden.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high; clears the counter on the next rising edge of clk.
- load_n  input  1  active-low synchronous parallel load; driven by the NAND decode.
- enp  input  1  count enable P (global step enable).
- ent  input  1  count enable T; feeds the first slice's carry chain.
- d  input  WIDTH  parallel load value (jump target).
- q  output  WIDTH  current count (PC value).
- slice_rco  output  NSLICE  per-slice ripple carry out, for bench visibility.
- rco  output  1  terminal carry of the last slice.

Behaviour:
- Reset:
  - rst=1 at a rising edge sets q=0 on that edge.
  - rst has top priority over load_n, enp and ent.
  - With q=0, slice_rco=0 and rco=0.
  - Asserting rst mid-count clears on the next edge; there is no partial state.
- Priority at each rising edge of clk: rst, then load, then count, then hold.
  - Load: rst=0 and load_n=0 gives q<=d on that edge. Load ignores enp and ent.
  - Count: rst=0, load_n=1, enp=1 and a slice's T-chain input =1 gives that slice nibble<=nibble+1 (mod 16).
  - Hold: otherwise q keeps its value.
- Carry chain (combinational):
  - t[0]=ent; t[i+1]=slice_rco[i].
  - slice_rco[i] = t[i] & (nibble_i==4'hF). The 74163 rule applies: RCO is gated by ENT, not ENP.
  - rco = slice_rco[NSLICE-1].
- Counting consequences:
  - The full counter increments by 1 per enabled cycle.
  - At q = all ones with enp=ent=1, the next edge gives q=0. rco=1 during the all-ones cycle, 0 after.
  - ent=0: the count is frozen, all slice_rco=0 and rco=0, whatever enp is.
  - enp=0, ent=1: the count is frozen, but slice_rco still reflects nibble==F propagation. rco can be 1 while holding.
- Latency:
  - Load and count take effect one clock after sampling; q updates on the edge.
  - rco and slice_rco change combinationally with q and ent within the same cycle.
- Simultaneous events:
  - load_n=0 together with a count condition: the load wins, with no increment of d.
  - load_n=0 together with rst=1: q=0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - d is sampled only on load.
  - There is no X-propagation tolerance: unknown inputs at an edge are a bench error, not defined behaviour.
- Structure:
  - Implement as NSLICE instances of an internal 4-bit slice with a generate loop. No behavioural add across the full WIDTH.
  - This keeps the carry path identical to a chained 74163 board.

Test Plan:
- Reset: drive rst=1 for 2 cycles with q preloaded to 8'h5A, enp=ent=1, load_n=0 -> q=8'h00, rco=0 after the first edge; rst still beats load.
- Count and slice carry: rst=0, load_n=1, enp=ent=1 from 8'h00 for 20 cycles -> q=8'h14.
  - slice_rco[0]=1 exactly when q=8'h0F and q=8'h1F would occur; q steps 8'h0F->8'h10.
- Wrap: load 8'hFE, then count with enp=ent=1.
  - q goes FE->FF->00.
  - rco=1 only in the FF cycle.
  - slice_rco=2'b11 at FF.
- Enables: at q=8'h3F, enp=0, ent=1 -> q holds 3F and slice_rco[0]=1.
  - Then ent=0 -> q holds and slice_rco=0, rco=0.
  - Then enp=ent=1 -> q=8'h40.
- Jump: with the count running at 8'h21, pulse load_n=0 for one cycle with d=8'hC7 -> next q=8'hC7 (not C8). Following cycles give C8, C9.
- WIDTH=12: run from 12'hFFD with enp=ent=1.
  - q goes FFD->FFE->FFF->000.
  - rco=1 only at FFF.
  - slice_rco=3'b111 at FFF.

Source files
------------

// File: rtl/pc_counter163.sv
// Program counter built from cascaded 74163-style 4-bit synchronous counter slices.
// Each slice has its own carry gating, so the carry path is the same as a chained board of slices.

module pc_counter163_slice (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    logic [3:0] nib_q;
    logic [3:0] nib_d;

    always_comb begin
        nib_d = nib_q;
        if (!load_n) begin
            nib_d = d;
        end else if (enp && ent) begin
            nib_d = nib_q + 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_q <= 4'h0;
        end else begin
            nib_q <= nib_d;
        end
    end

    assign q = nib_q;
    // Carry out is gated by ENT only; ENP only stops stepping, as on the 74163.
    assign rco = ent & (nib_q == 4'hF);

endmodule

module pc_counter163 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_n,
    input  logic               enp,
    input  logic               ent,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH/4-1:0] slice_rco,
    output logic               rco
);

    localparam int NSLICE = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("pc_counter163: WIDTH must be a non-zero multiple of 4");
    end

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        logic t_in;

        if (i == 0) begin : g_first
            assign t_in = ent;
        end else begin : g_chain
            assign t_in = slice_rco[i-1];
        end

        pc_counter163_slice u_slice (
            .clk    (clk),
            .rst    (rst),
            .load_n (load_n),
            .enp    (enp),
            .ent    (t_in),
            .d      (d[4*i +: 4]),
            .q      (q[4*i +: 4]),
            .rco    (slice_rco[i])
        );
    end

    assign rco = slice_rco[NSLICE-1];

endmodule

// File: tb/tb_pc_counter163.sv
// Directed bench for pc_counter163: vector table on an 8-bit instance plus
// hand sequences for the long count run and a 12-bit wrap.

module tb_pc_counter163;

    logic        clk;
    logic        rst, load_n, enp, ent;
    logic [7:0]  d;
    logic [7:0]  q8;
    logic [1:0]  src8;
    logic        rco8;

    logic        rst12, load_n12, enp12, ent12;
    logic [11:0] d12;
    logic [11:0] q12;
    logic [2:0]  src12;
    logic        rco12;

    int n_cmp = 0;
    int n_bad = 0;

    pc_counter163 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_n(load_n), .enp(enp), .ent(ent),
        .d(d), .q(q8), .slice_rco(src8), .rco(rco8)
    );

    pc_counter163 #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst12), .load_n(load_n12), .enp(enp12), .ent(ent12),
        .d(d12), .q(q12), .slice_rco(src12), .rco(rco12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       load_n;
        logic       enp;
        logic       ent;
        logic [7:0] d;
        logic [7:0] q;
        logic [1:0] src;
        logic       rco;
        string      name;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step8(input logic a_rst, input logic a_ld, input logic a_enp,
                         input logic a_ent, input logic [7:0] a_d);
        @(negedge clk);
        rst = a_rst; load_n = a_ld; enp = a_enp; ent = a_ent; d = a_d;
        @(posedge clk);
        #1;
    endtask

    task automatic step12(input logic a_rst, input logic a_ld, input logic a_enp,
                          input logic a_ent, input logic [11:0] a_d);
        @(negedge clk);
        rst12 = a_rst; load_n12 = a_ld; enp12 = a_enp; ent12 = a_ent; d12 = a_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, load_n, enp, ent, d  ->  q, slice_rco, rco
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 2'b00, 1'b0, "preload_5a"};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h00, 2'b00, 1'b0, "rst_beats_load1"};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h00, 2'b00, 1'b0, "rst_beats_load2"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 8'hFE, 2'b00, 1'b0, "load_fe"};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 2'b11, 1'b1, "count_ff"};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, "wrap_00"};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h3F, 8'h3F, 2'b01, 1'b0, "load_3f_enp0"};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h3F, 2'b01, 1'b0, "hold_enp0"};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3F, 2'b00, 1'b0, "hold_ent0"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h3F, 2'b00, 1'b0, "hold_ent0_enp1"};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h40, 2'b00, 1'b0, "count_40"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h20, 2'b00, 1'b0, "load_20"};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h21, 2'b00, 1'b0, "count_21"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC7, 8'hC7, 2'b00, 1'b0, "jump_c7"};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hC7, 8'hC8, 2'b00, 1'b0, "after_jump_c8"};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hC7, 8'hC9, 2'b00, 1'b0, "after_jump_c9"};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hC7, 8'h00, 2'b00, 1'b0, "rst_mid_count"};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 2'b11, 1'b1, "load_ff_enp0"};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 2'b11, 1'b1, "hold_ff_rco1"};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 2'b00, 1'b0, "hold_ff_ent0"};

        rst = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 8'h00;
        rst12 = 1'b1; load_n12 = 1'b1; enp12 = 1'b0; ent12 = 1'b0; d12 = 12'h000;

        for (int i = 0; i < 20; i++) begin
            step8(vecs[i].rst, vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].d);
            check({vecs[i].name, "_q"},   32'(q8),   32'(vecs[i].q));
            check({vecs[i].name, "_src"}, 32'(src8), 32'(vecs[i].src));
            check({vecs[i].name, "_rco"}, 32'(rco8), 32'(vecs[i].rco));
        end

        // Long run from zero: crosses the 0F->10 slice boundary.
        step8(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        check("run_reset_q", 32'(q8), 32'h00);
        for (int i = 1; i <= 20; i++) begin
            logic [7:0] exp_q;
            logic [1:0] exp_src;
            exp_q = 8'(i);
            exp_src = {exp_q == 8'hFF, exp_q[3:0] == 4'hF};
            step8(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
            check("run_q", 32'(q8), 32'(exp_q));
            check("run_src", 32'(src8), 32'(exp_src));
            check("run_rco", 32'(rco8), 32'(exp_q == 8'hFF));
        end
        check("run_final_14", 32'(q8), 32'h14);

        // 12-bit instance: three-slice carry at FFF.
        step12(1'b1, 1'b0, 1'b1, 1'b1, 12'hABC);
        check("w12_reset_q", 32'(q12), 32'h000);
        check("w12_reset_rco", 32'(rco12), 32'h0);
        step12(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFD);
        check("w12_load_q", 32'(q12), 32'hFFD);
        check("w12_load_src", 32'(src12), 32'h0);
        step12(1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        check("w12_ffe_q", 32'(q12), 32'hFFE);
        check("w12_ffe_rco", 32'(rco12), 32'h0);
        step12(1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        check("w12_fff_q", 32'(q12), 32'hFFF);
        check("w12_fff_src", 32'(src12), 32'h7);
        check("w12_fff_rco", 32'(rco12), 32'h1);
        step12(1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        check("w12_wrap_q", 32'(q12), 32'h000);
        check("w12_wrap_src", 32'(src12), 32'h0);
        check("w12_wrap_rco", 32'(rco12), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
